// File: rtl/store_serializer_pkg.sv
// Shared encodings for the store path: size codes, FSM states, alignment helpers.
package store_serializer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  // Size encodings shared with the load-extension logic
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when the size is legal and the low address bits fit its alignment
  function automatic logic req_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: req_ok = 1'b1;
      SZ_HALF: req_ok = (addr_lo[0] == 1'b0);
      SZ_WORD: req_ok = (addr_lo == 2'b00);
      default: req_ok = 1'b0;
    endcase
  endfunction

  // Index of the final byte for a legal size
  function automatic logic [IDX_W-1:0] size_last(input logic [1:0] size);
    case (size)
      SZ_HALF: size_last = 2'd1;
      SZ_WORD: size_last = 2'd3;
      default: size_last = 2'd0;
    endcase
  endfunction

  // Drop bits above the stored width
  function automatic logic [DATA_W-1:0] size_trunc(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] data);
    case (size)
      SZ_HALF: size_trunc = {16'h0000, data[15:0]};
      SZ_WORD: size_trunc = data;
      default: size_trunc = {24'h000000, data[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/store_serializer_if.sv
// Request port plus byte-wide memory port of the store serializer.
interface store_serializer_if #(
  parameter int unsigned ADDR_W = 32
);
  import store_serializer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ack,
    input  req_ready, mem_we, mem_addr, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ack,
    output req_ready, mem_we, mem_addr, mem_wdata, done, err
  );

endinterface

// File: rtl/store_serializer_lane_sel.sv
// Picks the byte lane of the latched store data for the current byte index.
module store_lane_sel
  import store_serializer_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [IDX_W-1:0]  last,
  input  logic [DATA_W-1:0] data,
  output logic [BYTE_W-1:0] byte_c
);

  logic [IDX_W-1:0] lane_c;

  // Big-endian walks from the most significant stored byte downward
  always_comb begin
    lane_c = idx;
    if (BIG_ENDIAN) lane_c = IDX_W'(last - idx);
    byte_c = BYTE_W'(data >> {lane_c, 3'b000});
  end

endmodule

// File: rtl/store_serializer.sv
// Narrowing store unit: truncates a register value and writes it one byte per memory handshake.
module store_serializer
  import store_serializer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input logic              clk,
  input logic              reset,
  store_serializer_if.slave bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BYTE_W-1:0] lane_byte_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Accept/reject in IDLE, step through bytes on each ack in BUSY
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    base_d  = base_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_ok(bus.req_size, bus.req_addr[1:0])) begin
            base_d  = bus.req_addr;
            data_d  = size_trunc(bus.req_size, bus.req_data);
            last_d  = size_last(bus.req_size);
            idx_d   = '0;
            state_d = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          if (idx_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = IDX_W'(idx_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  store_lane_sel #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_sel (
    .idx   (idx_q),
    .last  (last_q),
    .data  (data_q),
    .byte_c(lane_byte_c)
  );

  // Outputs decode registered state only; no path from ack or request inputs
  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_we    = (state_q == BUSY);
  assign bus.mem_addr  = base_q + ADDR_W'(idx_q);
  assign bus.mem_wdata = lane_byte_c;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_store_serializer.sv
// Directed bench for store_serializer: little- and big-endian instances on one clock.
module tb_store_serializer;
  import store_serializer_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  store_serializer_if #(.ADDR_W(32)) if0 ();
  store_serializer_if #(.ADDR_W(32)) if1 ();

  store_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  store_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full view of one port: we, addr, wdata, ready, done, err
  task automatic chk_le(input string tag, input logic we, input logic [31:0] addr,
                        input logic [7:0] wd, input logic rdy, input logic dn, input logic er);
    chk({tag, ".we"},    32'(if0.mem_we),    32'(we));
    if (we) begin
      chk({tag, ".addr"},  if0.mem_addr,       addr);
      chk({tag, ".wdata"}, 32'(if0.mem_wdata), 32'(wd));
    end
    chk({tag, ".ready"}, 32'(if0.req_ready), 32'(rdy));
    chk({tag, ".done"},  32'(if0.done),      32'(dn));
    chk({tag, ".err"},   32'(if0.err),       32'(er));
  endtask

  task automatic chk_be(input string tag, input logic we, input logic [31:0] addr,
                        input logic [7:0] wd, input logic rdy, input logic dn, input logic er);
    chk({tag, ".we"},    32'(if1.mem_we),    32'(we));
    if (we) begin
      chk({tag, ".addr"},  if1.mem_addr,       addr);
      chk({tag, ".wdata"}, 32'(if1.mem_wdata), 32'(wd));
    end
    chk({tag, ".ready"}, 32'(if1.req_ready), 32'(rdy));
    chk({tag, ".done"},  32'(if1.done),      32'(dn));
    chk({tag, ".err"},   32'(if1.err),       32'(er));
  endtask

  initial begin
    logic [7:0]  sw_bytes [4];
    logic [7:0]  sh_bytes [2];
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_data = '0; if0.req_size = '0; if0.mem_ack = 1'b0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_data = '0; if1.req_size = '0; if1.mem_ack = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_le.addr",  if0.mem_addr, 32'h0);
    chk("rst_le.wdata", 32'(if0.mem_wdata), 32'h0);
    chk_le("rst_le", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_be("rst_be", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // sw 0x100 = 0x11223344, little-endian, ack tied high
    sw_bytes[0] = 8'h44; sw_bytes[1] = 8'h33; sw_bytes[2] = 8'h22; sw_bytes[3] = 8'h11;
    if0.mem_ack   = 1'b1;
    if0.req_valid = 1'b1; if0.req_addr = 32'h100; if0.req_data = 32'h11223344; if0.req_size = SZ_WORD;
    step();
    if0.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_le($sformatf("sw_b%0d", i), 1'b1, 32'h100 + 32'(i), sw_bytes[i], 1'b0, 1'b0, 1'b0);
      step();
    end
    chk_le("sw_done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    chk_le("sw_after", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);

    // sh 0x202 = 0xDEADBEEF, big-endian, two wait cycles before each ack
    sh_bytes[0] = 8'hBE; sh_bytes[1] = 8'hEF;
    if1.mem_ack   = 1'b0;
    if1.req_valid = 1'b1; if1.req_addr = 32'h202; if1.req_data = 32'hDEADBEEF; if1.req_size = SZ_HALF;
    step();
    if1.req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 3; c++) begin
        if1.mem_ack = (c == 2);
        chk_be($sformatf("sh_b%0d_c%0d", b, c), 1'b1, 32'h202 + 32'(b), sh_bytes[b], 1'b0, 1'b0, 1'b0);
        step();
      end
    end
    if1.mem_ack = 1'b0;
    chk_be("sh_done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    chk_be("sh_after", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);

    // sb 0x7 = 0xAABBCCDD
    if0.req_valid = 1'b1; if0.req_addr = 32'h7; if0.req_data = 32'hAABBCCDD; if0.req_size = SZ_BYTE;
    step();
    if0.req_valid = 1'b0;
    chk_le("sb_b0", 1'b1, 32'h7, 8'hDD, 1'b0, 1'b0, 1'b0);
    step();
    chk_le("sb_done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();

    // Rejected requests: misaligned half, misaligned word, illegal size
    bad_addr[0] = 32'h301; bad_size[0] = SZ_HALF;
    bad_addr[1] = 32'h402; bad_size[1] = SZ_WORD;
    bad_addr[2] = 32'h500; bad_size[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      if0.req_valid = 1'b1; if0.req_addr = bad_addr[k]; if0.req_data = 32'hCAFEF00D; if0.req_size = bad_size[k];
      step();
      if0.req_valid = 1'b0;
      chk_le($sformatf("bad%0d_err", k), 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b1);
      step();
      chk_le($sformatf("bad%0d_after", k), 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Reset during second byte of a word store, then a clean sb
    if0.req_valid = 1'b1; if0.req_addr = 32'h10; if0.req_data = 32'h87654321; if0.req_size = SZ_WORD;
    step();
    if0.req_valid = 1'b0;
    chk_le("rst_sw_b0", 1'b1, 32'h10, 8'h21, 1'b0, 1'b0, 1'b0);
    step();
    chk_le("rst_sw_b1", 1'b1, 32'h11, 8'h43, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_le("rst_abort", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    chk_le("rst_abort2", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    if0.req_valid = 1'b1; if0.req_addr = 32'h20; if0.req_data = 32'h0000005A; if0.req_size = SZ_BYTE;
    step();
    if0.req_valid = 1'b0;
    chk_le("post_rst_sb", 1'b1, 32'h20, 8'h5A, 1'b0, 1'b0, 1'b0);
    step();
    chk_le("post_rst_done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();

    // Back-to-back sb with req_valid held: second accepted on first's done cycle
    if0.req_valid = 1'b1; if0.req_addr = 32'h30; if0.req_data = 32'h00000001; if0.req_size = SZ_BYTE;
    step();
    if0.req_addr = 32'h31; if0.req_data = 32'h00000002;
    chk_le("b2b_1", 1'b1, 32'h30, 8'h01, 1'b0, 1'b0, 1'b0);
    step();
    chk_le("b2b_done1", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    if0.req_valid = 1'b0;
    chk_le("b2b_2", 1'b1, 32'h31, 8'h02, 1'b0, 1'b0, 1'b0);
    step();
    chk_le("b2b_done2", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    chk_le("b2b_idle", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);

    // ack in IDLE is ignored
    if0.mem_ack = 1'b1;
    step();
    chk_le("idle_ack", 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
